// File: rtl/vga_fb_arbiter_pkg.sv
// Constants and state encoding shared by the VGA frame-buffer arbiter,
// its bus interface and the pixel shifter.
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_TOTAL  = 525;

    localparam int PIX_BITS     = 3;
    localparam int PIX_PER_WORD = 8;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = PIX_BITS * PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRD  = 2'd1,
        DCAP = 2'd2
    } fb_state_e;

    function automatic int words_per_line(input int h_active);
        return h_active / PIX_PER_WORD;
    endfunction
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer RAM port plus pixel-writer handshake, as seen by the arbiter
// (master) and by the RAM/writer side (slave).
interface vga_fb_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
        input  mem_rdata, wr_req, wr_addr, wr_data
    );

    modport slave (
        input  mem_addr, mem_rd, mem_we, mem_wdata, wr_ack,
        output mem_rdata, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_pix_shifter.sv
// Word buffer and 3-bit-per-pixel shift register feeding the registered
// r/g/b outputs, blanked outside the visible area.
module vga_pix_shifter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [10:0]       hcnt,
    input  logic [10:0]       vcnt,
    input  logic              cap,
    input  logic [DATA_W-1:0] rdata,
    output logic              r,
    output logic              g,
    output logic              b
);
    logic [DATA_W-1:0] word_buf;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic              active;
    logic              load;

    assign active   = (hcnt < 11'(H_ACTIVE)) && (vcnt < 11'(V_ACTIVE));
    assign load     = active && (hcnt[2:0] == 3'd0);
    assign shift_nx = load ? word_buf : (shift >> PIX_BITS);

    // Colour samples the shifter's next value, so pixel h leaves while hcnt == h+1.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            word_buf  <= '0;
            shift     <= '0;
            {b, g, r} <= 3'b000;
        end else begin
            if (cap) begin
                word_buf <= rdata;
            end
            shift <= shift_nx;
            if (active) begin
                {b, g, r} <= shift_nx[PIX_BITS-1:0];
            end else begin
                {b, g, r} <= 3'b000;
            end
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port frame-buffer RAM between VGA scan-out (always wins)
// and a pixel writer that takes every remaining cycle.
//
// state | meaning
// IDLE  | RAM free for the writer, waiting for a display fetch slot
// DRD   | display read on the RAM, writer held off for this cycle
// DCAP  | read data captured into the word buffer, RAM free for the writer
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [10:0]      hcnt,
    input  logic [10:0]      vcnt,
    vga_fb_arbiter_if.master bus,
    output logic             r,
    output logic             g,
    output logic             b,
    output logic             line_fetch
);
    localparam int                WORDS     = words_per_line(H_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WORDS);

    fb_state_e         state;
    fb_state_e         state_nx;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] base_nx;
    logic [ADDR_W-1:0] k_off;
    logic [10:0]       hn;
    logic              synced;
    logic              slot_word0;
    logic              slot_wordk;
    logic              fetch_go;
    logic              write_ok;

    // Slots are decoded one pixel early so DRD lands exactly on hcnt == slot.
    assign hn = hcnt + 11'd1;

    // Mid-line words are held off after reset until a word-0 fetch has
    // re-established the line, so a restarted frame shows black, not garbage.
    always_comb begin
        slot_word0 = (hn == 11'(H_TOTAL - 4)) &&
                     ((vcnt == 11'(V_TOTAL - 1)) || (vcnt < 11'(V_ACTIVE - 1)));
        slot_wordk = synced && (hn[2:0] == 3'd4) &&
                     (hn < 11'(H_ACTIVE - 8)) && (vcnt < 11'(V_ACTIVE));
        k_off      = ADDR_W'((hn + 11'd4) >> 3);
        base_nx    = line_base;
        if (slot_word0) begin
            base_nx = (vcnt == 11'(V_TOTAL - 1)) ? '0 : line_base + LINE_STEP;
        end
        fetch_go   = (state == IDLE) && (slot_word0 || slot_wordk);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.mem_rd    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.wr_ack    = 1'b0;
        line_fetch    = 1'b0;
        write_ok      = bus.wr_req && (state != DRD) && !RST;

        case (state)
            IDLE:    if (fetch_go) state_nx = DRD;
            DRD:     state_nx = DCAP;
            DCAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (state == DRD) begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = fetch_addr;
            line_fetch   = 1'b1;
        end else if (write_ok) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wdata = bus.wr_data;
            bus.wr_ack    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            line_base  <= '0;
            fetch_addr <= '0;
            synced     <= 1'b0;
        end else if (fetch_go) begin
            line_base  <= base_nx;
            fetch_addr <= slot_word0 ? base_nx : line_base + k_off;
            if (slot_word0) begin
                synced <= 1'b1;
            end
        end
    end

    vga_pix_shifter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .DATA_W   (DATA_W)
    ) u_shifter (
        .clk   (clk),
        .RST   (RST),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .cap   (state == DCAP),
        .rdata (bus.mem_rdata),
        .r     (r),
        .g     (g),
        .b     (b)
    );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter on a shrunken raster, checked every
// cycle against a frame-level model of fetch slots, addresses and pixels.
module tb_vga_fb_arbiter;
    localparam int HA = 64;
    localparam int VA = 6;
    localparam int HT = 80;
    localparam int VT = 10;
    localparam int AW = 8;
    localparam int DW = 24;
    localparam int W  = HA / 8;

    logic        clk = 1'b0;
    logic        RST;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        r, g, b, line_fetch;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(
        .H_ACTIVE (HA), .V_ACTIVE (VA), .H_TOTAL (HT), .V_TOTAL (VT),
        .ADDR_W   (AW), .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .bus        (bus),
        .r          (r),
        .g          (g),
        .b          (b),
        .line_fetch (line_fetch)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM: synchronous, read data one cycle after mem_rd.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] shadow [256];
    logic          init_ram;

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= shadow[i];
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, h, v, $time);
        end
    endtask

    // Model state: raster position, whether scan-out is locked to a line,
    // current line base address, fetched words of the line, pending pixel.
    int            h, v;
    bit            armed;
    int            base;
    logic [DW-1:0] line_words [W];
    logic [2:0]    pend;
    bit            last_ack;
    bit            cur_rd;
    int            cnt_rd;
    bit            line_clean;

    function automatic bit is_w0(input int hh, input int vv);
        return (hh == HT - 4) && ((vv == VT - 1) || (vv < VA - 1));
    endfunction

    function automatic bit is_wk(input int hh, input int vv);
        return (vv < VA) && (hh % 8 == 4) && (hh >= 4) && (hh <= HA - 12);
    endfunction

    function automatic bit slot_now();
        return is_w0(h, v) || (armed && is_wk(h, v));
    endfunction

    task automatic check_cycle();
        bit w0, rd_e, we_e;
        int a, k;
        w0   = is_w0(h, v);
        rd_e = !RST && slot_now();
        we_e = !RST && bus.wr_req && !rd_e;
        k    = w0 ? 0 : (h + 4) / 8;
        a    = w0 ? ((v == VT - 1) ? 0 : base + W) : base + k;
        cur_rd = rd_e;

        if (h == 0) begin
            cnt_rd     = 0;
            line_clean = armed && !RST;
        end
        if (RST) line_clean = 0;
        if (bus.mem_rd) cnt_rd++;

        check("rd", bus.mem_rd, rd_e);
        check("fetch", line_fetch, rd_e);
        check("we", bus.mem_we, we_e);
        check("ack", bus.wr_ack, we_e);
        check("excl", bus.mem_rd & bus.mem_we, 1'b0);
        check("rgb", {b, g, r}, RST ? 3'b000 : pend);
        if (rd_e) check(w0 && v == VT - 1 ? "wrap_addr" : "raddr", bus.mem_addr, a);
        if (we_e) begin
            check("waddr", bus.mem_addr, bus.wr_addr);
            check("wdata", bus.mem_wdata, bus.wr_data);
        end
        if (RST) check("rst_addr", bus.mem_addr, 0);
        if (h == HT - 1 && line_clean)
            check("rdcount", cnt_rd,
                  (v < VA - 1) ? W : (v == VA - 1) ? W - 1 : (v == VT - 1) ? 1 : 0);

        last_ack = bus.wr_ack;
        if (RST) begin
            armed = 0;
            base  = 0;
            pend  = 3'b000;
            for (int i = 0; i < W; i++) line_words[i] = '0;
        end else begin
            if (rd_e) begin
                line_words[k] = shadow[a];
                if (w0) begin
                    armed = 1;
                    base  = a;
                end
            end
            if (we_e) shadow[bus.wr_addr] = bus.wr_data;
            pend = (h < HA && v < VA) ? line_words[h / 8][3 * (h % 8) +: 3] : 3'b000;
        end
    endtask

    // mode: 0 idle, 1 random writer, 2 constant writer, 3 request on fetch slots
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
        hcnt = 11'(h);
        vcnt = 11'(v);
        case (mode)
            1: begin
                if (!bus.wr_req || last_ack) begin
                    bus.wr_req = ($urandom_range(0, 99) < 40);
                    bus.wr_addr = AW'($urandom_range(0, 63));
                    bus.wr_data = DW'($urandom);
                end
            end
            2: begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = AW'(100);
                bus.wr_data = 24'hFFFFFF;
            end
            3: begin
                if (bus.wr_req && last_ack) begin
                    bus.wr_req = 1'b0;
                end else if (!bus.wr_req && slot_now()) begin
                    bus.wr_req  = 1'b1;
                    bus.wr_addr = AW'($urandom_range(0, 63));
                    bus.wr_data = DW'($urandom);
                end
            end
            default: bus.wr_req = 1'b0;
        endcase
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        int  ncoll;
        bit  coll_prev;
        bit  found;

        RST         = 1'b1;
        init_ram    = 1'b1;
        h           = 19;
        v           = 0;
        hcnt        = 11'(h);
        vcnt        = 11'(v);
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        armed       = 0;
        base        = 0;
        pend        = 3'b000;
        last_ack    = 0;
        cnt_rd      = 0;
        line_clean  = 0;
        for (int i = 0; i < W; i++) line_words[i] = '0;
        for (int i = 0; i < 256; i++) shadow[i] = DW'($urandom);

        repeat (3) step(0);
        init_ram = 1'b0;
        RST      = 1'b0;

        // Random writer traffic across two frames.
        repeat (2 * HT * VT) step(1);

        // Constant writer: acked on every cycle that is not a display read.
        repeat (200) step(2);
        step(0);
        check("rb100", ram[100], 24'hFFFFFF);

        // Requests raised exactly on display-read cycles.
        ncoll     = 0;
        coll_prev = 0;
        for (int i = 0; i < 2000 && ncoll < 4; i++) begin
            step(3);
            if (coll_prev) check("dcap_ack", bus.wr_ack, 1'b1);
            coll_prev = bus.wr_req && cur_rd;
            if (coll_prev) begin
                ncoll++;
                check("drd_we", bus.mem_we, 1'b0);
                check("drd_ack", bus.wr_ack, 1'b0);
            end
        end
        step(0);
        check("coll_seen", ncoll >= 4, 1'b1);

        // Reset pulse in the middle of visible line 2.
        found = 0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            step(0);
            found = (v == 2 && h == 29);
        end
        check("rst_point", found, 1'b1);
        @(posedge clk);
        #1;
        RST = 1'b1;
        h++;
        hcnt = 11'(h);
        @(negedge clk);
        check_cycle();
        step(0);
        step(0);
        #1;
        RST = 1'b0;

        repeat (HT * VT + 2 * HT) step(1);
        repeat (HT) step(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
